// File: rtl/merge_logic_mux_pkg.sv
// Shared merge-tree types: coupler hold-register states and default bundle geometry.
package merge_logic_mux_pkg;
   localparam int unsigned DEF_DATA_WIDTH   = 64;
   localparam int unsigned DEF_BUNDLE_WIDTH = 8;
   localparam int unsigned BUNDLE_BITS      = DEF_DATA_WIDTH * DEF_BUNDLE_WIDTH;
   localparam int unsigned CPL_BITS         = 2 * BUNDLE_BITS + 1;

   typedef enum logic [1:0] {
      H_EMPTY = 2'd0,
      H_LO    = 2'd1,
      H_HI    = 2'd2
   } hold_state_t;
endpackage

// File: rtl/merge_logic_mux_coupler_splitter.sv
// Holds one coupled word and emits it as two bundles, low half first; last rides on the high half.
module coupler_splitter
   import merge_logic_mux_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int unsigned BUNDLE_WIDTH = DEF_BUNDLE_WIDTH
) (
   input  logic                                   i_clk,
   input  logic                                   i_rst_n,
   input  logic                                   i_en,
   input  logic [2*BUNDLE_WIDTH*DATA_WIDTH:0]     i_coupler_data,
   input  logic                                   i_coupler_data_vld,
   output logic                                   o_coupler_read,
   output logic [BUNDLE_WIDTH*DATA_WIDTH:0]       o_data,
   output logic                                   o_vld,
   input  logic                                   i_rdy,
   output logic                                   o_empty
);
   localparam int unsigned BB = BUNDLE_WIDTH * DATA_WIDTH;

   hold_state_t         r_state;
   hold_state_t         w_state_nxt;
   logic [2*BB:0]       r_hold;
   logic                w_pop;

   always_comb begin
      w_pop       = i_coupler_data_vld & i_en &
                    ((r_state == H_EMPTY) | ((r_state == H_HI) & i_rdy));
      w_state_nxt = r_state;
      o_data      = '0;
      o_vld       = 1'b0;
      case (r_state)
         H_EMPTY: if (w_pop) w_state_nxt = H_LO;
         H_LO: begin
            o_vld  = 1'b1;
            o_data = {1'b0, r_hold[BB-1:0]};
            if (i_rdy) w_state_nxt = H_HI;
         end
         H_HI: begin
            o_vld  = 1'b1;
            o_data = {r_hold[2*BB], r_hold[2*BB-1:BB]};
            // refill in the same cycle the high half leaves keeps 1 bundle/cycle
            if (i_rdy) w_state_nxt = w_pop ? H_LO : H_EMPTY;
         end
         default: w_state_nxt = H_EMPTY;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= H_EMPTY;
         r_hold  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_pop) r_hold <= i_coupler_data;
      end
   end

   assign o_coupler_read = w_pop;
   assign o_empty        = (r_state == H_EMPTY);
endmodule

// File: rtl/merge_logic_mux.sv
// Leaf-side merge-level input stage: phase-selected source, registered output stream, transfer counters.
module merge_logic_mux
   import merge_logic_mux_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int unsigned BUNDLE_WIDTH = DEF_BUNDLE_WIDTH,
   parameter int unsigned CNT_WIDTH    = 32
) (
   input  logic                                i_clk,
   input  logic                                i_rst_n,
   input  logic                                i_phase_sel,
   input  logic [BUNDLE_WIDTH*DATA_WIDTH:0]    i_rd_data,
   input  logic                                i_rd_data_vld,
   output logic                                o_rd_read,
   input  logic [2*BUNDLE_WIDTH*DATA_WIDTH:0]  i_coupler_data,
   input  logic                                i_coupler_data_vld,
   output logic                                o_coupler_read,
   output logic [BUNDLE_WIDTH*DATA_WIDTH:0]    o_leaf_data,
   output logic                                o_leaf_data_vld,
   input  logic                                i_leaf_read,
   output logic                                o_phase,
   output logic                                o_idle,
   input  logic                                i_cnt_clr,
   output logic [CNT_WIDTH-1:0]                o_bundle_cnt,
   output logic [CNT_WIDTH-1:0]                o_last_cnt
);
   localparam int unsigned BB = BUNDLE_WIDTH * DATA_WIDTH;

   logic                 r_phase;
   logic [BB:0]          r_leaf_data;
   logic                 r_leaf_vld;
   logic [CNT_WIDTH-1:0] r_bundle_cnt;
   logic [CNT_WIDTH-1:0] r_last_cnt;

   logic                 w_adv;
   logic                 w_sw_pend;
   logic                 w_rd_pop;
   logic                 w_cpl_pop;
   logic [BB:0]          w_spl_data;
   logic                 w_spl_vld;
   logic                 w_spl_empty;
   logic                 w_xfer;

   assign w_adv     = ~r_leaf_vld | i_leaf_read;
   assign w_sw_pend = (i_phase_sel != r_phase);
   assign w_rd_pop  = ~r_phase & w_adv & i_rd_data_vld & ~w_sw_pend;
   assign w_xfer    = r_leaf_vld & i_leaf_read;

   coupler_splitter #(
      .DATA_WIDTH   (DATA_WIDTH),
      .BUNDLE_WIDTH (BUNDLE_WIDTH)
   ) u_splitter (
      .i_clk              (i_clk),
      .i_rst_n            (i_rst_n),
      .i_en               (r_phase & ~w_sw_pend),
      .i_coupler_data     (i_coupler_data),
      .i_coupler_data_vld (i_coupler_data_vld),
      .o_coupler_read     (w_cpl_pop),
      .o_data             (w_spl_data),
      .o_vld              (w_spl_vld),
      .i_rdy              (w_adv & r_phase),
      .o_empty            (w_spl_empty)
   );

   // pops are masked combinationally during reset so nothing is lost upstream
   assign o_rd_read      = w_rd_pop & i_rst_n;
   assign o_coupler_read = w_cpl_pop & i_rst_n;
   assign o_idle         = w_spl_empty & ~r_leaf_vld;
   assign o_phase        = r_phase;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_phase     <= 1'b0;
         r_leaf_vld  <= 1'b0;
         r_leaf_data <= '0;
      end else begin
         if (o_idle) r_phase <= i_phase_sel;
         if (w_adv) begin
            if (r_phase) begin
               r_leaf_vld <= w_spl_vld;
               if (w_spl_vld) r_leaf_data <= w_spl_data;
            end else begin
               r_leaf_vld <= w_rd_pop;
               if (w_rd_pop) r_leaf_data <= i_rd_data;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_bundle_cnt <= '0;
         r_last_cnt   <= '0;
      end else if (i_cnt_clr) begin
         r_bundle_cnt <= '0;
         r_last_cnt   <= '0;
      end else if (w_xfer) begin
         r_bundle_cnt <= r_bundle_cnt + CNT_WIDTH'(1);
         if (r_leaf_data[BB]) r_last_cnt <= r_last_cnt + CNT_WIDTH'(1);
      end
   end

   assign o_leaf_data     = r_leaf_data;
   assign o_leaf_data_vld = r_leaf_vld;
   assign o_bundle_cnt    = r_bundle_cnt;
   assign o_last_cnt      = r_last_cnt;
endmodule

// File: tb/tb_merge_logic_mux.sv
// Directed bench for merge_logic_mux: both phases, phase switch, backpressure, counter clear, reset.
module tb_merge_logic_mux;
   localparam int BB = 512;

   logic            i_clk = 1'b0;
   logic            i_rst_n;
   logic            i_phase_sel;
   logic [BB:0]     i_rd_data;
   logic            i_rd_data_vld;
   logic            o_rd_read;
   logic [2*BB:0]   i_coupler_data;
   logic            i_coupler_data_vld;
   logic            o_coupler_read;
   logic [BB:0]     o_leaf_data;
   logic            o_leaf_data_vld;
   logic            i_leaf_read;
   logic            o_phase;
   logic            o_idle;
   logic            i_cnt_clr;
   logic [31:0]     o_bundle_cnt;
   logic [31:0]     o_last_cnt;

   int n_cmp = 0;
   int n_err = 0;

   merge_logic_mux #(.DATA_WIDTH(64), .BUNDLE_WIDTH(8), .CNT_WIDTH(32)) dut (
      .i_clk              (i_clk),
      .i_rst_n            (i_rst_n),
      .i_phase_sel        (i_phase_sel),
      .i_rd_data          (i_rd_data),
      .i_rd_data_vld      (i_rd_data_vld),
      .o_rd_read          (o_rd_read),
      .i_coupler_data     (i_coupler_data),
      .i_coupler_data_vld (i_coupler_data_vld),
      .o_coupler_read     (o_coupler_read),
      .o_leaf_data        (o_leaf_data),
      .o_leaf_data_vld    (o_leaf_data_vld),
      .i_leaf_read        (i_leaf_read),
      .o_phase            (o_phase),
      .o_idle             (o_idle),
      .i_cnt_clr          (i_cnt_clr),
      .o_bundle_cnt       (o_bundle_cnt),
      .o_last_cnt         (o_last_cnt)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [BB-1:0] bun(input logic [7:0] k);
      return {8{56'hA55A0000000000, k}};
   endfunction

   function automatic logic [2*BB:0] cw(input logic last, input logic [7:0] lo, input logic [7:0] hi);
      return {last, bun(hi), bun(lo)};
   endfunction

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic clr_cnt();
      i_cnt_clr = 1'b1;
      cyc();
      i_cnt_clr = 1'b0;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0; i_rd_data_vld = 1'b1; i_coupler_data_vld = 1'b1;
      #2;
      n_cmp++; if (o_leaf_data_vld !== 1'b0) begin n_err++; $display("FAIL rst_vld got %b exp 0", o_leaf_data_vld); end
      n_cmp++; if (o_leaf_data !== '0) begin n_err++; $display("FAIL rst_data got %h exp 0", o_leaf_data); end
      n_cmp++; if (o_idle !== 1'b1) begin n_err++; $display("FAIL rst_idle got %b exp 1", o_idle); end
      n_cmp++; if (o_rd_read !== 1'b0) begin n_err++; $display("FAIL rst_rd_read got %b exp 0", o_rd_read); end
      n_cmp++; if (o_coupler_read !== 1'b0) begin n_err++; $display("FAIL rst_cpl_read got %b exp 0", o_coupler_read); end
      n_cmp++; if (o_phase !== 1'b0) begin n_err++; $display("FAIL rst_phase got %b exp 0", o_phase); end
      n_cmp++; if (o_bundle_cnt !== 32'd0 || o_last_cnt !== 32'd0) begin n_err++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", o_bundle_cnt, o_last_cnt); end
      i_rd_data_vld = 1'b0; i_coupler_data_vld = 1'b0;
      cyc(); cyc();
      i_rst_n = 1'b1;
      cyc();
      n_cmp++; if (o_idle !== 1'b1 || o_leaf_data_vld !== 1'b0) begin n_err++; $display("FAIL post_rst got idle=%b vld=%b exp 1/0", o_idle, o_leaf_data_vld); end
   endtask

   task automatic test_phase1();
      clr_cnt();
      i_phase_sel = 1'b0; i_leaf_read = 1'b1;
      i_rd_data = {1'b0, bun(8'h0A)}; i_rd_data_vld = 1'b1;
      #1;
      n_cmp++; if (o_rd_read !== 1'b1) begin n_err++; $display("FAIL p1_read got %b exp 1", o_rd_read); end
      cyc();
      n_cmp++; if (o_leaf_data_vld !== 1'b1 || o_leaf_data !== {1'b0, bun(8'h0A)}) begin n_err++; $display("FAIL p1_A got %b %h exp 1 %h", o_leaf_data_vld, o_leaf_data, {1'b0, bun(8'h0A)}); end
      i_rd_data = {1'b0, bun(8'h0B)};
      cyc();
      n_cmp++; if (o_leaf_data_vld !== 1'b1 || o_leaf_data !== {1'b0, bun(8'h0B)}) begin n_err++; $display("FAIL p1_B got %b %h exp 1 %h", o_leaf_data_vld, o_leaf_data, {1'b0, bun(8'h0B)}); end
      i_rd_data = {1'b1, bun(8'h0C)};
      cyc();
      n_cmp++; if (o_leaf_data_vld !== 1'b1 || o_leaf_data !== {1'b1, bun(8'h0C)}) begin n_err++; $display("FAIL p1_C got %b %h exp 1 %h", o_leaf_data_vld, o_leaf_data, {1'b1, bun(8'h0C)}); end
      i_rd_data_vld = 1'b0;
      cyc();
      n_cmp++; if (o_leaf_data_vld !== 1'b0) begin n_err++; $display("FAIL p1_drain got %b exp 0", o_leaf_data_vld); end
      n_cmp++; if (o_bundle_cnt !== 32'd3 || o_last_cnt !== 32'd1) begin n_err++; $display("FAIL p1_cnt got %0d/%0d exp 3/1", o_bundle_cnt, o_last_cnt); end
   endtask

   task automatic test_phase_switch();
      i_phase_sel = 1'b0; i_leaf_read = 1'b0;
      i_rd_data = {1'b0, bun(8'h0D)}; i_rd_data_vld = 1'b1;
      cyc();
      n_cmp++; if (o_leaf_data_vld !== 1'b1) begin n_err++; $display("FAIL sw_loaded got %b exp 1", o_leaf_data_vld); end
      i_rd_data = {1'b0, bun(8'h0E)};
      i_phase_sel = 1'b1; i_leaf_read = 1'b1;
      i_coupler_data = cw(1'b0, 8'h10, 8'h11); i_coupler_data_vld = 1'b1;
      #1;
      n_cmp++; if (o_rd_read !== 1'b0 || o_coupler_read !== 1'b0) begin n_err++; $display("FAIL sw_pend_reads got %b/%b exp 0/0", o_rd_read, o_coupler_read); end
      n_cmp++; if (o_phase !== 1'b0 || o_idle !== 1'b0) begin n_err++; $display("FAIL sw_pend_phase got %b idle %b exp 0/0", o_phase, o_idle); end
      cyc();
      n_cmp++; if (o_phase !== 1'b0 || o_idle !== 1'b1 || o_leaf_data_vld !== 1'b0) begin n_err++; $display("FAIL sw_drained got phase=%b idle=%b vld=%b exp 0/1/0", o_phase, o_idle, o_leaf_data_vld); end
      n_cmp++; if (o_rd_read !== 1'b0 || o_coupler_read !== 1'b0) begin n_err++; $display("FAIL sw_drained_reads got %b/%b exp 0/0", o_rd_read, o_coupler_read); end
      cyc();
      n_cmp++; if (o_phase !== 1'b1) begin n_err++; $display("FAIL sw_phase got %b exp 1", o_phase); end
      n_cmp++; if (o_coupler_read !== 1'b1 || o_rd_read !== 1'b0) begin n_err++; $display("FAIL sw_first_pop got %b/%b exp 1/0", o_coupler_read, o_rd_read); end
      i_rd_data_vld = 1'b0; i_coupler_data_vld = 1'b0;
   endtask

   task automatic test_phase2_single();
      clr_cnt();
      i_leaf_read = 1'b1;
      i_coupler_data = cw(1'b1, 8'h20, 8'h21); i_coupler_data_vld = 1'b1;
      #1;
      n_cmp++; if (o_coupler_read !== 1'b1) begin n_err++; $display("FAIL p2s_pop got %b exp 1", o_coupler_read); end
      cyc();
      i_coupler_data_vld = 1'b0;
      #1;
      n_cmp++; if (o_coupler_read !== 1'b0 || o_leaf_data_vld !== 1'b0) begin n_err++; $display("FAIL p2s_pop1 got read=%b vld=%b exp 0/0", o_coupler_read, o_leaf_data_vld); end
      cyc();
      n_cmp++; if (o_leaf_data_vld !== 1'b1 || o_leaf_data !== {1'b0, bun(8'h20)}) begin n_err++; $display("FAIL p2s_lo got %b %h exp 1 %h", o_leaf_data_vld, o_leaf_data, {1'b0, bun(8'h20)}); end
      cyc();
      n_cmp++; if (o_leaf_data_vld !== 1'b1 || o_leaf_data !== {1'b1, bun(8'h21)}) begin n_err++; $display("FAIL p2s_hi got %b %h exp 1 %h", o_leaf_data_vld, o_leaf_data, {1'b1, bun(8'h21)}); end
      cyc();
      n_cmp++; if (o_leaf_data_vld !== 1'b0 || o_idle !== 1'b1) begin n_err++; $display("FAIL p2s_end got vld=%b idle=%b exp 0/1", o_leaf_data_vld, o_idle); end
      n_cmp++; if (o_bundle_cnt !== 32'd2 || o_last_cnt !== 32'd1) begin n_err++; $display("FAIL p2s_cnt got %0d/%0d exp 2/1", o_bundle_cnt, o_last_cnt); end
   endtask

   task automatic test_phase2_stream();
      int idx;
      logic exp_rd;
      clr_cnt();
      i_leaf_read = 1'b1;
      idx = 0;
      for (int k = 0; k < 10; k++) begin
         if (k >= 2) begin
            n_cmp++;
            if (o_leaf_data_vld !== 1'b1 || o_leaf_data !== {(k == 9), bun(8'(8'h30 + k - 2))}) begin
               n_err++; $display("FAIL p2b_out%0d got %b %h exp 1 %h", k, o_leaf_data_vld, o_leaf_data, {(k == 9), bun(8'(8'h30 + k - 2))});
            end
         end else begin
            n_cmp++; if (o_leaf_data_vld !== 1'b0) begin n_err++; $display("FAIL p2b_out%0d got vld %b exp 0", k, o_leaf_data_vld); end
         end
         if (idx < 4) begin
            i_coupler_data = cw(idx == 3, 8'(8'h30 + 2*idx), 8'(8'h31 + 2*idx));
            i_coupler_data_vld = 1'b1;
         end else begin
            i_coupler_data_vld = 1'b0;
         end
         #1;
         exp_rd = (k < 8) && (k % 2 == 0);
         n_cmp++; if (o_coupler_read !== exp_rd) begin n_err++; $display("FAIL p2b_read%0d got %b exp %b", k, o_coupler_read, exp_rd); end
         if (exp_rd) idx++;
         cyc();
      end
      n_cmp++; if (o_leaf_data_vld !== 1'b0) begin n_err++; $display("FAIL p2b_end got vld %b exp 0", o_leaf_data_vld); end
      n_cmp++; if (o_bundle_cnt !== 32'd8 || o_last_cnt !== 32'd1) begin n_err++; $display("FAIL p2b_cnt got %0d/%0d exp 8/1", o_bundle_cnt, o_last_cnt); end
   endtask

   task automatic test_backpressure();
      clr_cnt();
      i_leaf_read = 1'b1;
      i_coupler_data = cw(1'b0, 8'h40, 8'h41); i_coupler_data_vld = 1'b1;
      cyc();
      i_coupler_data = cw(1'b1, 8'h42, 8'h43);
      cyc();
      i_leaf_read = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_cmp++; if (o_leaf_data_vld !== 1'b1 || o_leaf_data !== {1'b0, bun(8'h40)}) begin n_err++; $display("FAIL bp_hold%0d got %b %h exp 1 %h", i, o_leaf_data_vld, o_leaf_data, {1'b0, bun(8'h40)}); end
         n_cmp++; if (o_coupler_read !== 1'b0) begin n_err++; $display("FAIL bp_read%0d got %b exp 0", i, o_coupler_read); end
         cyc();
      end
      i_leaf_read = 1'b1;
      #1;
      n_cmp++; if (o_coupler_read !== 1'b1) begin n_err++; $display("FAIL bp_release_read got %b exp 1", o_coupler_read); end
      cyc();
      n_cmp++; if (o_leaf_data !== {1'b0, bun(8'h41)}) begin n_err++; $display("FAIL bp_hi0 got %h exp %h", o_leaf_data, {1'b0, bun(8'h41)}); end
      i_coupler_data_vld = 1'b0;
      cyc();
      n_cmp++; if (o_leaf_data !== {1'b0, bun(8'h42)}) begin n_err++; $display("FAIL bp_lo1 got %h exp %h", o_leaf_data, {1'b0, bun(8'h42)}); end
      cyc();
      n_cmp++; if (o_leaf_data !== {1'b1, bun(8'h43)}) begin n_err++; $display("FAIL bp_hi1 got %h exp %h", o_leaf_data, {1'b1, bun(8'h43)}); end
      cyc();
      n_cmp++; if (o_leaf_data_vld !== 1'b0 || o_bundle_cnt !== 32'd4 || o_last_cnt !== 32'd1) begin n_err++; $display("FAIL bp_cnt got vld=%b %0d/%0d exp 0 4/1", o_leaf_data_vld, o_bundle_cnt, o_last_cnt); end
   endtask

   task automatic test_cnt_clr_coincident();
      i_leaf_read = 1'b1;
      i_coupler_data = cw(1'b1, 8'h50, 8'h51); i_coupler_data_vld = 1'b1;
      cyc();
      i_coupler_data_vld = 1'b0;
      cyc();
      n_cmp++; if (o_leaf_data !== {1'b0, bun(8'h50)} || o_leaf_data_vld !== 1'b1) begin n_err++; $display("FAIL clr_lo got %b %h exp 1 %h", o_leaf_data_vld, o_leaf_data, {1'b0, bun(8'h50)}); end
      i_cnt_clr = 1'b1;
      cyc();
      i_cnt_clr = 1'b0;
      n_cmp++; if (o_bundle_cnt !== 32'd0 || o_last_cnt !== 32'd0) begin n_err++; $display("FAIL clr_prio got %0d/%0d exp 0/0", o_bundle_cnt, o_last_cnt); end
      cyc();
      n_cmp++; if (o_bundle_cnt !== 32'd1 || o_last_cnt !== 32'd1) begin n_err++; $display("FAIL clr_after got %0d/%0d exp 1/1", o_bundle_cnt, o_last_cnt); end
   endtask

   task automatic test_reset_mid();
      i_leaf_read = 1'b1;
      i_coupler_data = cw(1'b1, 8'h60, 8'h61); i_coupler_data_vld = 1'b1;
      cyc();
      i_coupler_data_vld = 1'b0;
      cyc();
      i_leaf_read = 1'b0;
      cyc();
      n_cmp++; if (o_leaf_data_vld !== 1'b1 || o_idle !== 1'b0) begin n_err++; $display("FAIL rm_pre got vld=%b idle=%b exp 1/0", o_leaf_data_vld, o_idle); end
      i_rst_n = 1'b0;
      #1;
      n_cmp++; if (o_leaf_data_vld !== 1'b0 || o_leaf_data !== '0 || o_idle !== 1'b1) begin n_err++; $display("FAIL rm_rst got vld=%b idle=%b data=%h exp 0/1/0", o_leaf_data_vld, o_idle, o_leaf_data); end
      n_cmp++; if (o_bundle_cnt !== 32'd0 || o_last_cnt !== 32'd0 || o_phase !== 1'b0) begin n_err++; $display("FAIL rm_cnt got %0d/%0d phase=%b exp 0/0/0", o_bundle_cnt, o_last_cnt, o_phase); end
      #2;
      i_rst_n = 1'b1; i_leaf_read = 1'b1;
      cyc();
      n_cmp++; if (o_leaf_data_vld !== 1'b0 || o_idle !== 1'b1 || o_phase !== 1'b1) begin n_err++; $display("FAIL rm_after got vld=%b idle=%b phase=%b exp 0/1/1", o_leaf_data_vld, o_idle, o_phase); end
      cyc();
      n_cmp++; if (o_leaf_data_vld !== 1'b0 || o_bundle_cnt !== 32'd0) begin n_err++; $display("FAIL rm_nopartial got vld=%b cnt=%0d exp 0/0", o_leaf_data_vld, o_bundle_cnt); end
   endtask

   initial begin
      i_rst_n = 1'b0; i_phase_sel = 1'b0; i_rd_data = '0; i_rd_data_vld = 1'b0;
      i_coupler_data = '0; i_coupler_data_vld = 1'b0; i_leaf_read = 1'b0; i_cnt_clr = 1'b0;
      test_reset();
      test_phase1();
      test_phase_switch();
      test_phase2_single();
      test_phase2_stream();
      test_backpressure();
      test_cnt_clr_coincident();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/merge_logic_mux.md
Name: merge_logic_mux

Overview:
Leaf-side input stage of a merge tree level; the mirror of the root-side demux.
- Phase 1 (i_phase_sel=0): passes bundles from the read burst buffer straight to leaf merge logic.
- Phase 2 (i_phase_sel=1): takes double-width coupled words from the previous level's root coupler and splits each into two bundles, low half first.
- Output is a registered valid/ready stream to the leaf merge logic, plus bundle and last counters.

Parameters:
DATA_WIDTH, 64, width of one record
BUNDLE_WIDTH, 8, records per bundle
CNT_WIDTH, 32, width of statistics counters

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_phase_sel  in  1  0: phase 1; 1: phase 2
i_rd_data  in  BUNDLE_WIDTH*DATA_WIDTH+1  phase-1 input {last, bundle}, first-word-fall-through
i_rd_data_vld  in  1  phase-1 head valid
o_rd_read  out  1  pops phase-1 head this cycle
i_coupler_data  in  2*BUNDLE_WIDTH*DATA_WIDTH+1  phase-2 input {last, hi bundle, lo bundle}, first-word-fall-through
i_coupler_data_vld  in  1  coupler head valid
o_coupler_read  out  1  pops coupler head this cycle
o_leaf_data  out  BUNDLE_WIDTH*DATA_WIDTH+1  {last, bundle} to leaf merge logic
o_leaf_data_vld  out  1  output valid
i_leaf_read  in  1  leaf accepts; a transfer occurs when vld & read
o_phase  out  1  phase currently in effect (phase_q)
o_idle  out  1  hold register empty and output register empty
i_cnt_clr  in  1  synchronous clear of counters
o_bundle_cnt  out  CNT_WIDTH  output transfers, wraps modulo 2^CNT_WIDTH
o_last_cnt  out  CNT_WIDTH  output transfers with last=1, wraps

Behaviour:
- Reset (async, i_rst_n=0):
  - o_leaf_data=0, o_leaf_data_vld=0.
  - Hold state = H_EMPTY, phase_q=0, both counters 0.
  - o_idle=1; o_rd_read and o_coupler_read are 0 while in reset.
- adv = ~o_leaf_data_vld | i_leaf_read. The output register loads only when adv=1; otherwise o_leaf_data and o_leaf_data_vld hold stable.
- Phase latch:
  - sw_pend = (i_phase_sel != phase_q).
  - While sw_pend=1, no new upstream pops occur.
  - phase_q takes i_phase_sel on the edge where o_idle=1, so the new phase is visible on the next cycle.
  - Data already inside the block always drains in the old phase.
- Phase 1 (phase_q=0):
  - o_rd_read = adv & i_rd_data_vld & ~sw_pend.
  - On a pop, the output register loads i_rd_data; latency is 1 cycle.
  - Throughput is 1 bundle per cycle.
- Phase 2 (phase_q=1): hold register keeps the coupled word and uses state H_EMPTY / H_LO / H_HI.
  - pop = i_coupler_data_vld & ~sw_pend & (state==H_EMPTY | (state==H_HI & adv)); o_coupler_read = pop.
  - H_EMPTY, pop → H_LO; word is captured.
  - H_LO, adv → H_HI; output = {0, lo}.
  - H_HI, adv → output = {last, hi}; next state is H_LO if pop, else H_EMPTY.
  - No adv: state holds.
  - Latency from pop to first o_leaf_data_vld is 2 cycles. Steady state is 1 bundle per cycle, with o_coupler_read alternating 1,0.
  - The last flag is attached only to the hi half.
- Output register always holds one bundle at a time. A pop and an output transfer in the same cycle is legal and lossless.
- Counters:
  - On each transfer: o_bundle_cnt +1; o_last_cnt +1 if last=1.
  - i_cnt_clr has priority over a simultaneous increment; the result is 0.
  - Counters wrap modulo 2^CNT_WIDTH without any flag.
- Reset asserted mid-word discards the hold contents and the output bundle; no partial output follows reset.
- Upstream valid with head data changing while not popped is tolerated; data is only sampled on a pop.

Decomposition:
- Shared package, merge tree types: hold-state enum (H_EMPTY, H_LO, H_HI) and localparams for BUNDLE_BITS = BUNDLE_WIDTH*DATA_WIDTH and CPL_BITS = 2*BUNDLE_BITS+1.
- One sub-module: coupler_splitter, containing the hold register, FSM and pop logic. It exposes a {last, bundle} valid/ready stream.
- The top level contains the phase latch, the phase mux, the output register and the counters.

Test Plan:
- Phase 1, 3 bundles A,B,C valid back-to-back, i_leaf_read=1 → A,B,C on consecutive cycles, each 1 cycle after its pop; o_bundle_cnt=3.
- Phase 2, single word {1, H, L} → L with last=0 at pop+2, H with last=1 at pop+3; o_last_cnt=1; state returns to H_EMPTY, o_idle=1.
- Phase 2, 4 words continuously valid, leaf always ready → 8 bundles on 8 consecutive cycles; o_coupler_read pattern 1,0,1,0,1,0,1,0.
- Backpressure: i_leaf_read=0 for 5 cycles while H output pending → o_leaf_data stable, o_coupler_read=0; after release, no loss or duplication (bundle_cnt delta = 2 per word).
- Phase switch 0→1 with out_vld=1 → o_rd_read=0 from that cycle; o_phase stays 0 until o_idle=1, then becomes 1 on the next cycle; first coupler pop follows.
- Reset pulse in H_HI state → next cycle o_leaf_data_vld=0, counters 0, o_idle=1. Separately, i_cnt_clr coincident with a transfer → o_bundle_cnt=0.
